// File: rtl/rename_pkg.sv
// Shared types, default geometry and helpers for the N-wide rename stage.
package rename_pkg;

   localparam int ARF_DEPTH_DEF = 32;
   localparam int ROB_DEPTH_DEF = 64;
   localparam int DATA_W_DEF    = 32;
   localparam int ARF_W         = $clog2(ARF_DEPTH_DEF);
   localparam int ROB_W         = $clog2(ROB_DEPTH_DEF);

   // RAT entry: register has an in-flight producer identified by robid
   typedef struct packed {
      logic             busy;
      logic [ROB_W-1:0] robid;
   } rat_entry_t;

   // One retire port as seen by the rename stage
   typedef struct packed {
      logic                  we;
      logic [ARF_W-1:0]      areg;
      logic [ROB_W-1:0]      robid;
      logic [DATA_W_DEF-1:0] data;
   } retire_slot_t;

   // Number of set bits in a group of up to four slot strobes
   function automatic logic [2:0] popcount4(input logic [3:0] v);
      popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/rename_arf.sv
// Architectural register file: NR read ports, NW write ports, same-cycle
// write-to-read forwarding, highest write port wins, register 0 reads zero.
module rename_arf #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int DW    = 32,
   parameter int NW    = 2,
   parameter int NR    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NW-1:0]   we,
   input  logic [NW*AW-1:0] waddr,
   input  logic [NW*DW-1:0] wdata,
   input  logic [NR*AW-1:0] raddr,
   output logic [NR*DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Retire writes; later ports are assigned last so the highest port wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int w = 0; w < NW; w++)
            if (we[w] && waddr[w*AW +: AW] != '0)
               mem[waddr[w*AW +: AW]] <= wdata[w*DW +: DW];
      end
   end

   generate
      for (genvar gi = 0; gi < NR; gi++) begin : g_rd
         logic [AW-1:0] a;
         logic [DW-1:0] val;
         assign a = raddr[gi*AW +: AW];
         // Stored value, overridden by this cycle's writes (highest port last)
         always_comb begin
            val = mem[a];
            for (int w = 0; w < NW; w++)
               if (we[w] && waddr[w*AW +: AW] == a) val = wdata[w*DW +: DW];
            if (a == '0) val = '0;
         end
         assign rdata[gi*DW +: DW] = val;
      end
   endgenerate

endmodule

// File: rtl/r_rename_nw.sv
// N-wide rename stage: ROB id allocation, busy/robid RAT, in-group bypass,
// retire forwarding, registered stall-safe output and flush acknowledge.
module r_rename_nw
   import rename_pkg::*;
#(
   parameter int WIDTH     = 2,
   parameter int ARF_DEPTH = ARF_DEPTH_DEF,
   parameter int ROB_DEPTH = ROB_DEPTH_DEF,
   parameter int SRC_N     = 2,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int PAYLOAD_W = 64,
   localparam int AW = $clog2(ARF_DEPTH),
   localparam int RW = $clog2(ROB_DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          d_valid_i,
   output logic                          d_ready_o,
   input  logic [WIDTH-1:0]              d_slot_v_i,
   input  logic [WIDTH*SRC_N*AW-1:0]     d_src_i,
   input  logic [WIDTH*SRC_N-1:0]        d_src_need_i,
   input  logic [WIDTH*AW-1:0]           d_dst_i,
   input  logic [WIDTH-1:0]              d_we_i,
   input  logic [WIDTH*PAYLOAD_W-1:0]    d_payload_i,
   output logic                          p_valid_o,
   input  logic                          p_ready_i,
   output logic [WIDTH-1:0]              p_slot_v_o,
   output logic [WIDTH*RW-1:0]           p_robid_o,
   output logic [WIDTH*AW-1:0]           p_dst_o,
   output logic [WIDTH-1:0]              p_we_o,
   output logic [WIDTH*PAYLOAD_W-1:0]    p_payload_o,
   output logic [WIDTH*SRC_N*RW-1:0]     p_src_robid_o,
   output logic [WIDTH*SRC_N-1:0]        p_src_rdy_o,
   output logic [WIDTH*SRC_N*DATA_W-1:0] p_src_data_o,
   input  logic [WIDTH-1:0]              c_retire_i,
   input  logic [WIDTH-1:0]              c_retire_we_i,
   input  logic [WIDTH*AW-1:0]           c_retire_areg_i,
   input  logic [WIDTH*RW-1:0]           c_retire_robid_i,
   input  logic [WIDTH*DATA_W-1:0]       c_retire_data_i,
   input  logic                          c_flush_i,
   output logic                          c_flush_ack_o
);

   localparam int NS = WIDTH * SRC_N;
   localparam int CW = RW + 1;

   logic                 run_reg;         // low until the first edge after reset
   logic [CW-1:0]        cnt_reg;
   logic [RW-1:0]        tail_reg;
   logic                 flush_pend_reg;
   logic [ARF_DEPTH-1:0] busy_reg;
   logic [RW-1:0]        robid_reg [ARF_DEPTH];

   logic                 alloc;
   logic [2:0]           n_alloc;
   logic [2:0]           n_retire;
   logic [WIDTH*RW-1:0]  slot_robid;
   logic [NS*RW-1:0]     src_robid;
   logic [NS-1:0]        src_rdy;
   logic [NS*DATA_W-1:0] src_data;
   logic [NS*DATA_W-1:0] arf_rdata;

   // A full ROB blocks the whole group regardless of how many slots are valid
   assign d_ready_o = run_reg && ((ROB_DEPTH - int'(cnt_reg)) >= WIDTH) &&
                      !c_flush_i && !flush_pend_reg && (!p_valid_o || p_ready_i);
   assign alloc     = d_valid_i && d_ready_o;
   assign n_alloc   = alloc ? popcount4(4'(d_slot_v_i)) : 3'd0;
   assign n_retire  = popcount4(4'(c_retire_i));
   assign c_flush_ack_o = flush_pend_reg;

   rename_arf #(
      .DEPTH(ARF_DEPTH), .AW(AW), .DW(DATA_W), .NW(WIDTH), .NR(NS)
   ) u_arf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (c_retire_i & c_retire_we_i),
      .waddr (c_retire_areg_i),
      .wdata (c_retire_data_i),
      .raddr (d_src_i),
      .rdata (arf_rdata)
   );

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
         assign slot_robid[gi*RW +: RW] = tail_reg + RW'(gi);
      end

      for (genvar gi = 0; gi < NS; gi++) begin : g_src
         localparam int K = gi / SRC_N;
         logic [AW-1:0]     a;
         logic              hit;
         logic [RW-1:0]     rid;
         logic              rdy;
         logic [DATA_W-1:0] dat;
         // Resolve one source: zero/unused, in-group producer, RAT producer, ARF
         always_comb begin
            a   = d_src_i[gi*AW +: AW];
            hit = 1'b0;
            rid = '0;
            rdy = 1'b1;
            dat = '0;
            if (a != '0 && d_src_need_i[gi]) begin
               for (int j = 0; j < K; j++)
                  if (d_slot_v_i[j] && d_we_i[j] && d_dst_i[j*AW +: AW] == a) begin
                     hit = 1'b1;
                     rid = slot_robid[j*RW +: RW];
                  end
               if (hit) begin
                  rdy = 1'b0;
               end else if (busy_reg[a]) begin
                  rid = robid_reg[a];
                  rdy = 1'b0;
                  for (int r = 0; r < WIDTH; r++)
                     if (c_retire_i[r] && c_retire_we_i[r] &&
                         c_retire_areg_i[r*AW +: AW] == a &&
                         c_retire_robid_i[r*RW +: RW] == rid) begin
                        rdy = 1'b1;
                        dat = c_retire_data_i[r*DATA_W +: DATA_W];
                     end
               end else begin
                  dat = arf_rdata[gi*DATA_W +: DATA_W];
               end
            end
         end
         assign src_robid[gi*RW +: RW]         = rid;
         assign src_rdy[gi]                    = rdy;
         assign src_data[gi*DATA_W +: DATA_W]  = dat;
      end
   endgenerate

   // Occupancy, tail, RAT; rename writes are assigned after retire clears so they win
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_reg        <= 1'b0;
         cnt_reg        <= '0;
         tail_reg       <= '0;
         flush_pend_reg <= 1'b0;
         busy_reg       <= '0;
         for (int i = 0; i < ARF_DEPTH; i++) robid_reg[i] <= '0;
      end else begin
         run_reg        <= 1'b1;
         flush_pend_reg <= c_flush_i;
         if (c_flush_i) begin
            cnt_reg  <= '0;
            tail_reg <= '0;
            busy_reg <= '0;
         end else begin
            cnt_reg  <= cnt_reg + CW'(n_alloc) - CW'(n_retire);
            tail_reg <= tail_reg + RW'(n_alloc);
            for (int r = 0; r < WIDTH; r++)
               if (c_retire_i[r] && c_retire_we_i[r] &&
                   busy_reg[c_retire_areg_i[r*AW +: AW]] &&
                   robid_reg[c_retire_areg_i[r*AW +: AW]] == c_retire_robid_i[r*RW +: RW])
                  busy_reg[c_retire_areg_i[r*AW +: AW]] <= 1'b0;
            if (alloc)
               for (int k = 0; k < WIDTH; k++)
                  if (d_slot_v_i[k] && d_we_i[k] && d_dst_i[k*AW +: AW] != '0) begin
                     busy_reg[d_dst_i[k*AW +: AW]]  <= 1'b1;
                     robid_reg[d_dst_i[k*AW +: AW]] <= slot_robid[k*RW +: RW];
                  end
         end
      end
   end

   // Output group register: loads on alloc, holds while P stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_valid_o     <= 1'b0;
         p_slot_v_o    <= '0;
         p_robid_o     <= '0;
         p_dst_o       <= '0;
         p_we_o        <= '0;
         p_payload_o   <= '0;
         p_src_robid_o <= '0;
         p_src_rdy_o   <= '0;
         p_src_data_o  <= '0;
      end else if (c_flush_i) begin
         p_valid_o <= 1'b0;
      end else if (alloc) begin
         p_valid_o     <= 1'b1;
         p_slot_v_o    <= d_slot_v_i;
         p_robid_o     <= slot_robid;
         p_dst_o       <= d_dst_i;
         p_we_o        <= d_we_i;
         p_payload_o   <= d_payload_i;
         p_src_robid_o <= src_robid;
         p_src_rdy_o   <= src_rdy;
         p_src_data_o  <= src_data;
      end else if (p_ready_i) begin
         p_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_r_rename_nw.sv
// Randomised bench for r_rename_nw: a ROB-order reference model predicts each
// renamed group, a monitor compares whatever the DUT presents on p_*.
module tb_r_rename_nw;

   localparam int W  = 2;
   localparam int AD = 8;
   localparam int RD = 8;
   localparam int S  = 2;
   localparam int DW = 32;
   localparam int PW = 16;
   localparam int AW = 3;
   localparam int RW = 3;
   localparam int NS = W * S;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              d_valid_i, d_ready_o;
   logic [W-1:0]      d_slot_v_i, d_we_i;
   logic [NS*AW-1:0]  d_src_i;
   logic [NS-1:0]     d_src_need_i;
   logic [W*AW-1:0]   d_dst_i;
   logic [W*PW-1:0]   d_payload_i;
   logic              p_valid_o, p_ready_i;
   logic [W-1:0]      p_slot_v_o, p_we_o;
   logic [W*RW-1:0]   p_robid_o;
   logic [W*AW-1:0]   p_dst_o;
   logic [W*PW-1:0]   p_payload_o;
   logic [NS*RW-1:0]  p_src_robid_o;
   logic [NS-1:0]     p_src_rdy_o;
   logic [NS*DW-1:0]  p_src_data_o;
   logic [W-1:0]      c_retire_i, c_retire_we_i;
   logic [W*AW-1:0]   c_retire_areg_i;
   logic [W*RW-1:0]   c_retire_robid_i;
   logic [W*DW-1:0]   c_retire_data_i;
   logic              c_flush_i, c_flush_ack_o;

   r_rename_nw #(
      .WIDTH(W), .ARF_DEPTH(AD), .ROB_DEPTH(RD), .SRC_N(S), .DATA_W(DW), .PAYLOAD_W(PW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_slot_v_i(d_slot_v_i),
      .d_src_i(d_src_i), .d_src_need_i(d_src_need_i), .d_dst_i(d_dst_i),
      .d_we_i(d_we_i), .d_payload_i(d_payload_i),
      .p_valid_o(p_valid_o), .p_ready_i(p_ready_i), .p_slot_v_o(p_slot_v_o),
      .p_robid_o(p_robid_o), .p_dst_o(p_dst_o), .p_we_o(p_we_o),
      .p_payload_o(p_payload_o), .p_src_robid_o(p_src_robid_o),
      .p_src_rdy_o(p_src_rdy_o), .p_src_data_o(p_src_data_o),
      .c_retire_i(c_retire_i), .c_retire_we_i(c_retire_we_i),
      .c_retire_areg_i(c_retire_areg_i), .c_retire_robid_i(c_retire_robid_i),
      .c_retire_data_i(c_retire_data_i),
      .c_flush_i(c_flush_i), .c_flush_ack_o(c_flush_ack_o)
   );

   typedef struct {
      logic [W-1:0]     slot_v;
      logic [W*RW-1:0]  robid, slot_m;
      logic [W*AW-1:0]  dst, dst_m;
      logic [W-1:0]     we;
      logic [W*PW-1:0]  payload, pay_m;
      logic [NS-1:0]    srdy, srdy_m;
      logic [NS*RW-1:0] srob, srob_m;
      logic [NS*DW-1:0] sdat, sdat_m;
   } exp_t;

   typedef struct {
      logic [RW-1:0] robid;
      logic          we;
      logic [AW-1:0] areg;
   } rob_t;

   exp_t          q[$];        // groups expected on p_*, oldest first
   rob_t          inflight[$]; // allocated, not yet retired, in program order
   logic [DW-1:0] arf [AD];
   logic [RW-1:0] tail_m;
   logic          flush_pend_m;
   int            n_vec = 0;
   int            n_bad = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Monitor: compare whatever the DUT holds on p_* against the oldest expectation
   initial begin
      exp_t m;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("p_valid", 128'(p_valid_o), 128'(q.size() != 0));
            if (p_valid_o && q.size() != 0) begin
               m = q[0];
               chk("slot_v",    128'(p_slot_v_o), 128'(m.slot_v));
               chk("robid",     128'(p_robid_o & m.slot_m), 128'(m.robid));
               chk("dst",       128'(p_dst_o & m.dst_m), 128'(m.dst));
               chk("we",        128'(p_we_o & m.slot_v), 128'(m.we));
               chk("payload",   128'(p_payload_o & m.pay_m), 128'(m.payload));
               chk("src_rdy",   128'(p_src_rdy_o & m.srdy_m), 128'(m.srdy));
               chk("src_robid", 128'(p_src_robid_o & m.srob_m), 128'(m.srob));
               chk("src_data",  128'(p_src_data_o & m.sdat_m), 128'(m.sdat));
               if (p_ready_i) begin
                  $display("xfer t=%0t slot_v=%b robid=%h src_rdy=%b", $time, p_slot_v_o, p_robid_o, p_src_rdy_o);
                  void'(q.pop_front());
               end
            end
         end
      end
   end

   // Driver and reference model
   initial begin
      exp_t          e, pend;
      logic          have_push, flush, acc, exp_rdy, found, retiring;
      int            nret, nslot, g, lim;
      logic [AW-1:0] a;
      logic [RW-1:0] rob;
      logic [DW-1:0] rv;
      logic [DW-1:0] rdat [W];
      logic [DW-1:0] arf_after [AD];

      have_push = 1'b0;
      d_valid_i = 0; d_slot_v_i = 0; d_src_i = 0; d_src_need_i = 0; d_dst_i = 0;
      d_we_i = 0; d_payload_i = 0; p_ready_i = 1; c_retire_i = 0; c_retire_we_i = 0;
      c_retire_areg_i = 0; c_retire_robid_i = 0; c_retire_data_i = 0; c_flush_i = 0;
      for (int i = 0; i < AD; i++) arf[i] = '0;
      tail_m = '0;
      flush_pend_m = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_p_valid", 128'(p_valid_o), 128'(0));
      chk("rst_ack",     128'(c_flush_ack_o), 128'(0));
      chk("rst_d_ready", 128'(d_ready_o), 128'(0));
      chk("rst_robid",   128'(p_robid_o), 128'(0));
      chk("rst_src",     128'(p_src_data_o), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);

      for (int cyc = 0; cyc < 3000; cyc++) begin
         #1;
         if (have_push) q.push_back(pend);
         have_push = 1'b0;
         if (flush_pend_m) q.delete();
         chk("flush_ack", 128'(c_flush_ack_o), 128'(flush_pend_m));

         // retire the oldest in-flight instructions, in order
         lim  = (inflight.size() < W) ? inflight.size() : W;
         nret = $urandom_range(0, lim);
         c_retire_i = 0; c_retire_we_i = 0; c_retire_areg_i = 0;
         c_retire_robid_i = 0; c_retire_data_i = 0;
         for (int r = 0; r < W; r++) begin
            rdat[r] = $urandom;
            if (r < nret) begin
               c_retire_i[r]                 = 1'b1;
               c_retire_we_i[r]              = inflight[r].we;
               c_retire_areg_i[r*AW +: AW]   = inflight[r].areg;
               c_retire_robid_i[r*RW +: RW]  = inflight[r].robid;
               c_retire_data_i[r*DW +: DW]   = rdat[r];
            end
         end
         flush = ($urandom_range(0, 59) == 0);
         c_flush_i = flush;

         d_valid_i = ($urandom_range(0, 9) < 8);
         nslot = $urandom_range(1, W);
         d_slot_v_i = 0; d_src_i = 0; d_src_need_i = 0; d_dst_i = 0; d_we_i = 0; d_payload_i = 0;
         for (int k = 0; k < nslot; k++) begin
            d_slot_v_i[k] = 1'b1;
            d_dst_i[k*AW +: AW] = AW'($urandom_range(0, AD - 1));
            d_we_i[k] = ($urandom_range(0, 9) < 7);
            d_payload_i[k*PW +: PW] = PW'($urandom);
            for (int s = 0; s < S; s++) begin
               d_src_i[(k*S+s)*AW +: AW] = AW'($urandom_range(0, AD - 1));
               d_src_need_i[k*S+s] = ($urandom_range(0, 3) != 0);
            end
         end
         p_ready_i = ($urandom_range(0, 3) != 0);

         #1;
         exp_rdy = ((RD - inflight.size()) >= W) && !flush && !flush_pend_m &&
                   (q.size() == 0 || p_ready_i);
         chk("d_ready", 128'(d_ready_o), 128'(exp_rdy));
         acc = d_valid_i && exp_rdy;

         if (acc) begin
            for (int i = 0; i < AD; i++) arf_after[i] = arf[i];
            for (int r = 0; r < nret; r++)
               if (inflight[r].we && inflight[r].areg != 0) arf_after[inflight[r].areg] = rdat[r];
            e = '{default: '0};
            e.slot_v = d_slot_v_i;
            for (int k = 0; k < nslot; k++) begin
               e.slot_m[k*RW +: RW]  = '1;
               e.robid[k*RW +: RW]   = tail_m + RW'(k);
               e.dst_m[k*AW +: AW]   = '1;
               e.dst[k*AW +: AW]     = d_dst_i[k*AW +: AW];
               e.we[k]               = d_we_i[k];
               e.pay_m[k*PW +: PW]   = '1;
               e.payload[k*PW +: PW] = d_payload_i[k*PW +: PW];
               for (int s = 0; s < S; s++) begin
                  g = k*S + s;
                  a = d_src_i[g*AW +: AW];
                  e.srdy_m[g] = 1'b1;
                  if (a == 0 || !d_src_need_i[g]) begin
                     e.srdy[g] = 1'b1;
                     e.sdat_m[g*DW +: DW] = '1;
                  end else begin
                     // producer = youngest earlier writer of a in program order
                     found = 1'b0; retiring = 1'b0; rob = '0; rv = '0;
                     for (int i = 0; i < inflight.size(); i++)
                        if (inflight[i].we && inflight[i].areg == a) begin
                           found = 1'b1;
                           rob = inflight[i].robid;
                           retiring = (i < nret);
                           if (i < nret) rv = rdat[i];
                        end
                     for (int j = 0; j < k; j++)
                        if (d_we_i[j] && d_dst_i[j*AW +: AW] == a) begin
                           found = 1'b1; retiring = 1'b0; rob = tail_m + RW'(j);
                        end
                     if (found && !retiring) begin
                        e.srdy[g] = 1'b0;
                        e.srob_m[g*RW +: RW] = '1;
                        e.srob[g*RW +: RW] = rob;
                     end else begin
                        e.srdy[g] = 1'b1;
                        e.sdat_m[g*DW +: DW] = '1;
                        e.sdat[g*DW +: DW] = found ? rv : arf_after[a];
                     end
                  end
               end
            end
            pend = e;
            have_push = 1'b1;
         end

         @(posedge clk);
         for (int r = 0; r < nret; r++)
            if (inflight[r].we && inflight[r].areg != 0) arf[inflight[r].areg] = rdat[r];
         for (int r = 0; r < nret; r++) void'(inflight.pop_front());
         if (flush) begin
            inflight.delete();
            tail_m = '0;
         end else if (acc) begin
            for (int k = 0; k < nslot; k++)
               inflight.push_back('{robid: RW'(tail_m + RW'(k)), we: d_we_i[k], areg: d_dst_i[k*AW +: AW]});
            tail_m = tail_m + RW'(nslot);
         end
         flush_pend_m = flush;
      end

      // Final stall, then reset while a group may be held
      #1;
      if (have_push) q.push_back(pend);
      have_push = 1'b0;
      if (flush_pend_m) q.delete();
      d_valid_i = 0; c_retire_i = 0; c_flush_i = 0; p_ready_i = 0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst2_p_valid", 128'(p_valid_o), 128'(0));
      chk("rst2_d_ready", 128'(d_ready_o), 128'(0));
      chk("rst2_payload", 128'(p_payload_o), 128'(0));
      chk("rst2_src_rdy", 128'(p_src_rdy_o), 128'(0));
      chk("rst2_ack",     128'(c_flush_ack_o), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
